// File: rtl/pool_engine.sv
`default_nettype none
// pool_engine: 2-D max/avg pooling engine. Loads layer params from SRAM, then
// walks the feature map window by window, writing one pooled element per window.
module pool_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32,
  parameter int MAX_K  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  output logic              busy_o,
  output logic              finish_o,
  output logic              err_o,
  output logic              param_cs_o,
  output logic [ADDR_W-1:0] param_addr_o,
  input  logic [31:0]       param_rdata_i,
  output logic              in_cs_o,
  output logic [ADDR_W-1:0] in_addr_o,
  input  logic [DATA_W-1:0] in_rdata_i,
  output logic              out_cs_o,
  output logic              out_we_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_wdata_o
);

  localparam int OW    = CNT_W + 2;
  localparam int ACC_W = DATA_W + 4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_READ, S_WRITE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0]  dim_n_q, dim_n_d, dim_c_q, dim_c_d;
  logic [CNT_W-1:0]  ker_q, ker_d, str_q, str_d;
  logic              k_hi_q, k_hi_d, avg_q, avg_d, ceil_q, ceil_d, err_q, err_d;
  logic [OW-1:0]     row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0]  ch_q, ch_d, kr_q, kr_d, kc_q, kc_d;
  logic [ADDR_W-1:0] ch_base_q, ch_base_d, out_cnt_q, out_cnt_d;
  logic              drain_q, drain_d, tap_v_q, tap_v_d, have_q, have_d;
  logic [ACC_W-1:0]  acc_q, acc_d;

  logic [OW-1:0]     w_lim, w_col_nx, w_row_nx, w_tap_row, w_tap_col;
  logic              w_keep_col, w_keep_row, w_keep_first, w_tap_ok, w_illegal;
  logic [ADDR_W-1:0] w_tap_addr, w_nn;
  logic [3:0]        w_klog;
  logic [4:0]        w_shift;
  logic [ACC_W-1:0]  w_shifted;
  logic [DATA_W-1:0] w_result;

  // An origin x is kept while x+K < lim: floor gives x+K <= N, ceil gives x < N-K+S.
  assign w_lim        = ceil_q ? (OW'(dim_n_q) + OW'(str_q)) : (OW'(dim_n_q) + OW'(1));
  assign w_col_nx     = col_q + OW'(str_q);
  assign w_row_nx     = row_q + OW'(str_q);
  assign w_keep_col   = (w_col_nx + OW'(ker_q)) < w_lim;
  assign w_keep_row   = (w_row_nx + OW'(ker_q)) < w_lim;
  assign w_keep_first = OW'(ker_q) < w_lim;

  assign w_tap_row  = row_q + OW'(kr_q);
  assign w_tap_col  = col_q + OW'(kc_q);
  assign w_tap_ok   = (w_tap_row < OW'(dim_n_q)) && (w_tap_col < OW'(dim_n_q));
  assign w_tap_addr = ch_base_q + ADDR_W'(w_tap_row) * ADDR_W'(dim_n_q) + ADDR_W'(w_tap_col);
  assign w_nn       = ADDR_W'(dim_n_q) * ADDR_W'(dim_n_q);

  assign w_illegal = (ker_q == '0) || k_hi_q || (ker_q > CNT_W'(MAX_K)) ||
                     (str_q == '0) || (dim_n_q == '0) || (dim_c_q == '0) ||
                     (!ceil_q && (dim_n_q < ker_q)) ||
                     (avg_q && ((ker_q & (ker_q - CNT_W'(1))) != '0));

  // Avg divides by K*K = 2^(2*log2 K); K is a checked power of two here.
  always_comb begin
    w_klog = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (ker_q == CNT_W'(1 << i)) w_klog = i[3:0];
    end
  end
  assign w_shift   = {w_klog, 1'b0};
  assign w_shifted = acc_q >> w_shift;
  assign w_result  = avg_q ? w_shifted[DATA_W-1:0] : acc_q[DATA_W-1:0];

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    dim_n_d   = dim_n_q;
    dim_c_d   = dim_c_q;
    ker_d     = ker_q;
    str_d     = str_q;
    k_hi_d    = k_hi_q;
    avg_d     = avg_q;
    ceil_d    = ceil_q;
    err_d     = err_q;
    row_d     = row_q;
    col_d     = col_q;
    ch_d      = ch_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    ch_base_d = ch_base_q;
    out_cnt_d = out_cnt_q;
    drain_d   = drain_q;
    tap_v_d   = 1'b0;
    have_d    = have_q;
    acc_d     = acc_q;

    busy_o       = 1'b0;
    finish_o     = 1'b0;
    param_cs_o   = 1'b0;
    param_addr_o = '0;
    in_cs_o      = 1'b0;
    in_addr_o    = '0;
    out_cs_o     = 1'b0;
    out_we_o     = 1'b0;
    out_addr_o   = '0;
    out_wdata_o  = '0;

    // Data for the tap issued last cycle lands now.
    if (tap_v_q) begin
      have_d = 1'b1;
      if (avg_q) begin
        acc_d = acc_q + ACC_W'(in_rdata_i);
      end else if (!have_q || (in_rdata_i > acc_q[DATA_W-1:0])) begin
        acc_d = ACC_W'(in_rdata_i);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_LOAD;
          err_d    = 1'b0;
          ld_cnt_d = '0;
        end
      end
      S_LOAD: begin
        busy_o = 1'b1;
        if (ld_cnt_q <= 3'd4) begin
          param_cs_o   = 1'b1;
          param_addr_o = ADDR_W'(ld_cnt_q);
        end
        case (ld_cnt_q)
          3'd1: dim_n_d = param_rdata_i[CNT_W-1:0];
          3'd2: dim_c_d = param_rdata_i[CNT_W-1:0];
          3'd3: begin
            ker_d  = param_rdata_i[CNT_W-1:0];
            k_hi_d = |param_rdata_i[31:CNT_W];
          end
          3'd4: str_d = param_rdata_i[CNT_W-1:0];
          3'd5: begin
            avg_d  = param_rdata_i[0];
            ceil_d = param_rdata_i[1];
          end
          default: ;
        endcase
        ld_cnt_d = ld_cnt_q + 3'd1;
        if (ld_cnt_q == 3'd5) state_d = S_CHECK;
      end
      S_CHECK: begin
        busy_o    = 1'b1;
        row_d     = '0;
        col_d     = '0;
        ch_d      = '0;
        ch_base_d = '0;
        out_cnt_d = '0;
        kr_d      = '0;
        kc_d      = '0;
        drain_d   = 1'b0;
        have_d    = 1'b0;
        acc_d     = '0;
        if (w_illegal) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!w_keep_first) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        busy_o = 1'b1;
        if (!drain_q) begin
          in_cs_o   = w_tap_ok;
          in_addr_o = w_tap_ok ? w_tap_addr : '0;
          tap_v_d   = w_tap_ok;
          if (kc_q == ker_q - CNT_W'(1)) begin
            kc_d = '0;
            if (kr_q == ker_q - CNT_W'(1)) begin
              kr_d    = '0;
              drain_d = 1'b1;
            end else begin
              kr_d = kr_q + CNT_W'(1);
            end
          end else begin
            kc_d = kc_q + CNT_W'(1);
          end
        end else begin
          drain_d = 1'b0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        busy_o      = 1'b1;
        out_cs_o    = 1'b1;
        out_we_o    = 1'b1;
        out_addr_o  = out_cnt_q;
        out_wdata_o = w_result;
        out_cnt_d   = out_cnt_q + ADDR_W'(1);
        have_d      = 1'b0;
        acc_d       = '0;
        if (w_keep_col) begin
          col_d = w_col_nx;
        end else begin
          col_d = '0;
          if (w_keep_row) begin
            row_d = w_row_nx;
          end else begin
            row_d     = '0;
            ch_d      = ch_q + CNT_W'(1);
            ch_base_d = ch_base_q + w_nn;
          end
        end
        if (!w_keep_col && !w_keep_row && (ch_q == dim_c_q - CNT_W'(1))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        finish_o  = 1'b1;
        row_d     = '0;
        col_d     = '0;
        ch_d      = '0;
        ch_base_d = '0;
        out_cnt_d = '0;
        kr_d      = '0;
        kc_d      = '0;
        ld_cnt_d  = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err_o = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      ld_cnt_q  <= '0;
      dim_n_q   <= '0;
      dim_c_q   <= '0;
      ker_q     <= '0;
      str_q     <= '0;
      k_hi_q    <= 1'b0;
      avg_q     <= 1'b0;
      ceil_q    <= 1'b0;
      err_q     <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      ch_q      <= '0;
      kr_q      <= '0;
      kc_q      <= '0;
      ch_base_q <= '0;
      out_cnt_q <= '0;
      drain_q   <= 1'b0;
      tap_v_q   <= 1'b0;
      have_q    <= 1'b0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      dim_n_q   <= dim_n_d;
      dim_c_q   <= dim_c_d;
      ker_q     <= ker_d;
      str_q     <= str_d;
      k_hi_q    <= k_hi_d;
      avg_q     <= avg_d;
      ceil_q    <= ceil_d;
      err_q     <= err_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ch_q      <= ch_d;
      kr_q      <= kr_d;
      kc_q      <= kc_d;
      ch_base_q <= ch_base_d;
      out_cnt_q <= out_cnt_d;
      drain_q   <= drain_d;
      tap_v_q   <= tap_v_d;
      have_q    <= have_d;
      acc_q     <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/pool_engine.md
Name: pool_engine

Overview:
- Parametrised 2-D pooling engine for the EPU.
- Reads layer parameters from a param SRAM, then sweeps a channel-major, row-major feature map in an input SRAM. Writes one pooled value per window to an output SRAM.
- Supports max or average pooling, programmable kernel and stride, and floor or ceil (edge-padding) output sizing.
- All SRAMs are single-port with 1-cycle read latency; the engine is the only master during a run.

Parameters:
- DATA_W, 8, element width (unsigned)
- ADDR_W, 32, SRAM address width
- MAX_K, 4, largest legal kernel_size
- CNT_W, 8, width of row/col/channel counters (max dim 255)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  run request, sampled in IDLE only
- busy  out  1  high from the cycle after start is accepted until DONE
- finish  out  1  one-cycle pulse in DONE
- err  out  1  sticky illegal-parameter flag; cleared on next accepted start
- param_cs  out  1  param SRAM select
- param_addr  out  ADDR_W  param word address
- param_rdata  in  32  param word, valid the cycle after the address
- in_cs  out  1  input SRAM select
- in_addr  out  ADDR_W  input element address
- in_rdata  in  DATA_W  input element, valid the cycle after the address
- out_cs  out  1  output SRAM select
- out_we  out  1  output write strobe
- out_addr  out  ADDR_W  output element address
- out_wdata  out  DATA_W  pooled value

Behaviour:
- Reset values:
  - busy, finish, err, all cs/we are 0.
  - All addresses and out_wdata are 0.
  - State is IDLE.
- Param map (words 0..4):
  - N (row = col count)
  - C (channels)
  - K (kernel)
  - S (stride)
  - mode: bit0 0=max, 1=avg; bit1 0=floor, 1=ceil
- States: IDLE -> LOAD_PARAM -> CHECK -> READ <-> WRITE -> DONE -> IDLE.
- IDLE:
  - start=1 moves to LOAD_PARAM and clears err.
  - start during any other state is ignored.
- LOAD_PARAM:
  - Issues addrs 0..4 on consecutive cycles and captures each word the following cycle.
  - Takes 6 cycles.
- CHECK (1 cycle): the following are illegal:
  - K=0, K>MAX_K, S=0, N=0, C=0
  - floor mode with N<K
  - avg with K not a power of two
  - Illegal: set err and go to DONE with no SRAM writes. Otherwise go to READ.
- Window origins along each axis are r = i*S, i = 0,1,...
  - Floor mode keeps r with r+K<=N.
  - Ceil mode keeps r with r<N-K+S.
  - No divider is used; the next origin is tested incrementally.
- READ:
  - Issues K*K addresses, row-major within the window: addr = ch*N*N + (r+kr)*N + (c+kc).
  - Taps with r+kr>=N or c+kc>=N (ceil mode only) are not issued to SRAM. They contribute nothing to max and 0 to avg.
  - Accumulator captures data one cycle after each address. The first valid tap initialises max.
  - Avg sum width is DATA_W+4. The result is sum >> log2(K*K), truncated.
- WRITE (1 cycle):
  - out_cs=out_we=1, out_wdata=result, out_addr = running count from 0.
  - Advances col, then row, then channel. After the last window of the last channel, goes to DONE; otherwise READ.
- Per-window latency: K*K issue cycles + 1 drain + 1 write.
- Outputs are packed densely: channel-major, then row, then col.
- DONE:
  - finish=1 for one cycle, busy=0.
  - Internal addresses and counters return to 0; err holds.
  - Next state is IDLE.
- Reset asserted mid-run forces IDLE immediately. A partial output is not completed.

Test Plan:
- N=4,C=1,K=2,S=2, max, floor, input 0..15 -> 4 writes at addr 0..3 = 5,7,13,15; finish pulse once.
- N=5,C=1,K=2,S=2, max, ceil, input 0..24 -> 9 writes = 6,8,9,16,18,19,21,23,24; no in_addr >= 25.
- N=4,C=2,K=2,S=2, avg, ch0 all 10, ch1 values 1,2,3,4 per window -> ch0 outputs 10 x4, ch1 outputs 2 (10>>2) x4 at addr 4..7.
- N=3,C=1,K=2,S=1, max, input 9,1,1,1,1,1,1,1,8 -> 4 writes = 9,1,1,8.
- K=0 (and separately avg with K=3) -> err=1, finish pulse, zero out_we cycles; next legal start clears err.
- Assert rstn low during READ of a 4x4 run -> all outputs at reset values next cycle; a new start completes a correct full run.
